// File: rtl/fractal_sync_node.sv
// Fractal barrier synchronisation node: collects child sync requests per barrier id,
// wakes children on local root completion and forwards aggregated or pass-through requests upward.
module fractal_sync_node #(
  parameter int N_PORTS    = 2,
  parameter int AGGR_WIDTH = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [N_PORTS-1:0]                   sync_i,
  input  logic [N_PORTS-1:0][AGGR_WIDTH-1:0]   aggr_i,
  input  logic [N_PORTS-1:0][ID_WIDTH-1:0]     id_i,
  output logic [N_PORTS-1:0]                   wake_o,
  output logic [N_PORTS-1:0]                   error_o,
  output logic                                 sync_o,
  output logic [AGGR_WIDTH-2:0]                aggr_o,
  output logic [ID_WIDTH-1:0]                  id_o,
  output logic [N_PORTS-1:0]                   src_o,
  input  logic                                 wake_i,
  input  logic [N_PORTS-1:0]                   dst_i,
  input  logic                                 error_i
);
  localparam int SD_WIDTH   = N_PORTS;
  localparam int N_BARRIERS = 2**ID_WIDTH;
  localparam int N_ITEMS    = N_BARRIERS + N_PORTS;
  localparam int PTR_W      = $clog2(N_ITEMS);
  localparam int PW         = $clog2(N_PORTS);

  logic [N_PORTS-1:0]                      busy_r, busy_s, fwd_r, fwd_s;
  logic [N_PORTS-1:0][AGGR_WIDTH-1:0]      faggr_r, faggr_s;
  logic [N_PORTS-1:0][ID_WIDTH-1:0]        fid_r, fid_s;
  logic [N_BARRIERS-1:0][N_PORTS-1:0]      arr_r, arr_s;
  logic [N_BARRIERS-1:0][AGGR_WIDTH-1:0]   baggr_r, baggr_s;
  logic [N_BARRIERS-1:0]                   pend_r, pend_s, complete_s, root_s;
  logic [PTR_W-1:0]                        ptr_r, ptr_s, idx_s, gidx_s;
  logic [PTR_W:0]                          sum_s;
  logic [PW-1:0]                           gp_s;
  logic [N_ITEMS-1:0]                      req_s;
  logic                                    found_s;
  logic [N_PORTS-1:0]                      wake_s, err_s, perr_s;
  logic                                    sync_s;
  logic [AGGR_WIDTH-2:0]                   aggr_s;
  logic [ID_WIDTH-1:0]                     id_s;
  logic [SD_WIDTH-1:0]                     src_s;

  // Next-state: accept/reject requests, detect completions, apply parent events, arbitrate upward.
  always_comb begin
    busy_s  = busy_r;
    fwd_s   = fwd_r;
    faggr_s = faggr_r;
    fid_s   = fid_r;
    arr_s   = arr_r;
    baggr_s = baggr_r;
    pend_s  = pend_r;
    ptr_s   = ptr_r;
    wake_s  = '0;
    err_s   = '0;
    sync_s  = 1'b0;
    aggr_s  = '0;
    id_s    = '0;
    src_s   = '0;
    found_s = 1'b0;
    gidx_s  = '0;
    gp_s    = '0;
    sum_s   = '0;
    idx_s   = '0;
    complete_s = '0;
    root_s     = '0;

    for (int p = 0; p < N_PORTS; p++) begin
      if (sync_i[p] && !busy_r[p] && aggr_i[p] != '0) begin
        if (aggr_i[p][0]) begin
          // Lower ports in the same cycle are already folded into arr_s/baggr_s.
          if (arr_s[id_i[p]] != '0 && baggr_s[id_i[p]] != aggr_i[p]) begin
            err_s[p] = 1'b1;
          end else begin
            arr_s[id_i[p]][p] = 1'b1;
            baggr_s[id_i[p]]  = aggr_i[p];
            busy_s[p]         = 1'b1;
          end
        end else begin
          fwd_s[p]   = 1'b1;
          faggr_s[p] = aggr_i[p];
          fid_s[p]   = id_i[p];
          busy_s[p]  = 1'b1;
        end
      end else begin
        err_s[p] = sync_i[p];
      end
    end

    for (int b = 0; b < N_BARRIERS; b++) begin
      complete_s[b] = (arr_s[b] == '1);
      root_s[b]     = complete_s[b] && (baggr_s[b] == AGGR_WIDTH'(1));
      if (root_s[b]) begin
        wake_s     = wake_s | arr_s[b];
        arr_s[b]   = '0;
        baggr_s[b] = '0;
      end else begin
        pend_s[b] = pend_r[b] | complete_s[b];
      end
    end

    perr_s = {N_PORTS{error_i}} & dst_i & busy_r;
    wake_s = wake_s | ({N_PORTS{wake_i}} & dst_i & busy_r);
    err_s  = err_s | perr_s;
    busy_s = busy_s & ~(wake_s | perr_s);

    req_s = {fwd_s, pend_s};
    for (int i = 0; i < N_ITEMS; i++) begin
      sum_s   = {1'b0, ptr_r} + (PTR_W+1)'(i);
      idx_s   = (sum_s >= (PTR_W+1)'(N_ITEMS)) ? PTR_W'(sum_s - (PTR_W+1)'(N_ITEMS))
                                               : sum_s[PTR_W-1:0];
      gidx_s  = (!found_s && req_s[idx_s]) ? idx_s : gidx_s;
      found_s = found_s | req_s[idx_s];
    end

    if (found_s) begin
      sync_s = 1'b1;
      ptr_s  = (gidx_s == PTR_W'(N_ITEMS-1)) ? '0 : gidx_s + PTR_W'(1);
      if (gidx_s < PTR_W'(N_BARRIERS)) begin
        aggr_s = baggr_s[gidx_s[ID_WIDTH-1:0]][AGGR_WIDTH-1:1];
        id_s   = gidx_s[ID_WIDTH-1:0];
        src_s  = '1;
        arr_s[gidx_s[ID_WIDTH-1:0]]   = '0;
        baggr_s[gidx_s[ID_WIDTH-1:0]] = '0;
        pend_s[gidx_s[ID_WIDTH-1:0]]  = 1'b0;
      end else begin
        gp_s        = PW'(gidx_s - PTR_W'(N_BARRIERS));
        aggr_s      = faggr_s[gp_s][AGGR_WIDTH-1:1];
        id_s        = fid_s[gp_s];
        src_s[gp_s] = 1'b1;
        fwd_s[gp_s] = 1'b0;
      end
    end else begin
      sync_s = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_r  <= '0;
      fwd_r   <= '0;
      faggr_r <= '0;
      fid_r   <= '0;
      arr_r   <= '0;
      baggr_r <= '0;
      pend_r  <= '0;
      ptr_r   <= '0;
      wake_o  <= '0;
      error_o <= '0;
      sync_o  <= 1'b0;
      aggr_o  <= '0;
      id_o    <= '0;
      src_o   <= '0;
    end else begin
      busy_r  <= busy_s;
      fwd_r   <= fwd_s;
      faggr_r <= faggr_s;
      fid_r   <= fid_s;
      arr_r   <= arr_s;
      baggr_r <= baggr_s;
      pend_r  <= pend_s;
      ptr_r   <= ptr_s;
      wake_o  <= wake_s;
      error_o <= err_s;
      sync_o  <= sync_s;
      aggr_o  <= aggr_s;
      id_o    <= id_s;
      src_o   <= src_s;
    end
  end
endmodule

// File: tb/tb_fractal_sync_node.sv
// Directed self-checking bench for fractal_sync_node with N_PORTS=2, AGGR_WIDTH=4, ID_WIDTH=2.
module tb_fractal_sync_node;
  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [1:0]      sync_i;
  logic [1:0][3:0] aggr_i;
  logic [1:0][1:0] id_i;
  logic [1:0]      wake_o, error_o;
  logic            sync_o;
  logic [2:0]      aggr_o;
  logic [1:0]      id_o;
  logic [1:0]      src_o;
  logic            wake_i;
  logic [1:0]      dst_i;
  logic            error_i;

  int errors = 0;
  int checks = 0;

  fractal_sync_node #(.N_PORTS(2), .AGGR_WIDTH(4), .ID_WIDTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sync_i(sync_i), .aggr_i(aggr_i), .id_i(id_i),
    .wake_o(wake_o), .error_o(error_o), .sync_o(sync_o), .aggr_o(aggr_o), .id_o(id_o),
    .src_o(src_o), .wake_i(wake_i), .dst_i(dst_i), .error_i(error_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    sync_i  = 2'b00;
    aggr_i  = '0;
    id_i    = '0;
    wake_i  = 1'b0;
    error_i = 1'b0;
    dst_i   = 2'b00;
  endtask

  // One cycle of child requests; afterwards outputs reflect that cycle.
  task automatic send(input logic [1:0] s, input logic [3:0] a0, input logic [1:0] i0,
                      input logic [3:0] a1, input logic [1:0] i1);
    sync_i = s;
    aggr_i[0] = a0; id_i[0] = i0;
    aggr_i[1] = a1; id_i[1] = i1;
    tick();
    idle();
  endtask

  task automatic parent(input logic w, input logic e, input logic [1:0] d);
    wake_i = w; error_i = e; dst_i = d;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b1;
    tick();
    tick();
    checks++;
    if ({wake_o, error_o, sync_o, aggr_o, id_o, src_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 000", {wake_o, error_o, sync_o, aggr_o, id_o, src_o});
    end
    rst_i = 1'b0;
  endtask

  task automatic test_root();
    do_reset();
    send(2'b01, 4'b0001, 2'd1, 4'b0000, 2'd0);
    checks++;
    if ({wake_o, sync_o, error_o} !== 5'b0) begin
      errors++; $display("FAIL root_first: got %b expected 00000", {wake_o, sync_o, error_o});
    end
    tick();
    send(2'b10, 4'b0000, 2'd0, 4'b0001, 2'd1);
    checks++;
    if (wake_o !== 2'b11) begin errors++; $display("FAIL root_wake: got %b expected 11", wake_o); end
    checks++;
    if (sync_o !== 1'b0) begin errors++; $display("FAIL root_no_sync: got %b expected 0", sync_o); end
    tick();
    checks++;
    if (wake_o !== 2'b00) begin errors++; $display("FAIL root_pulse: got %b expected 00", wake_o); end
  endtask

  task automatic test_aggregate();
    do_reset();
    send(2'b11, 4'b0011, 2'd2, 4'b0011, 2'd2);
    checks++;
    if ({sync_o, aggr_o, id_o, src_o} !== {1'b1, 3'b001, 2'd2, 2'b11}) begin
      errors++; $display("FAIL aggr_up: got %b expected 10011011", {sync_o, aggr_o, id_o, src_o});
    end
    tick();
    checks++;
    if ({sync_o, aggr_o, id_o, src_o} !== 8'h00) begin
      errors++; $display("FAIL aggr_idle_zero: got %b expected 00000000", {sync_o, aggr_o, id_o, src_o});
    end
    tick();
    tick();
    tick();
    parent(1'b1, 1'b0, 2'b11);
    checks++;
    if (wake_o !== 2'b11) begin errors++; $display("FAIL aggr_parent_wake: got %b expected 11", wake_o); end
    tick();
    checks++;
    if (wake_o !== 2'b00) begin errors++; $display("FAIL aggr_wake_pulse: got %b expected 00", wake_o); end
  endtask

  task automatic test_contention();
    do_reset();
    send(2'b11, 4'b0010, 2'd0, 4'b0100, 2'd3);
    checks++;
    if ({sync_o, aggr_o, id_o, src_o} !== {1'b1, 3'b001, 2'd0, 2'b01}) begin
      errors++; $display("FAIL fwd_first: got %b expected 10010001", {sync_o, aggr_o, id_o, src_o});
    end
    tick();
    checks++;
    if ({sync_o, aggr_o, id_o, src_o} !== {1'b1, 3'b010, 2'd3, 2'b10}) begin
      errors++; $display("FAIL fwd_second: got %b expected 10101110", {sync_o, aggr_o, id_o, src_o});
    end
    parent(1'b1, 1'b0, 2'b11);
    send(2'b10, 4'b0000, 2'd0, 4'b0011, 2'd3);
    checks++;
    if (sync_o !== 1'b0) begin errors++; $display("FAIL bar3_partial: got %b expected 0", sync_o); end
    send(2'b01, 4'b0011, 2'd3, 4'b0000, 2'd0);
    checks++;
    if ({sync_o, aggr_o, id_o, src_o} !== {1'b1, 3'b001, 2'd3, 2'b11}) begin
      errors++; $display("FAIL bar3_grant: got %b expected 10011111", {sync_o, aggr_o, id_o, src_o});
    end
  endtask

  task automatic test_round_robin();
    // Pointer sits at 4 after the barrier-3 grant; a port0 forward moves it to 5.
    parent(1'b1, 1'b0, 2'b11);
    send(2'b01, 4'b0010, 2'd1, 4'b0000, 2'd0);
    checks++;
    if ({sync_o, src_o} !== 3'b101) begin errors++; $display("FAIL rr_single: got %b expected 101", {sync_o, src_o}); end
    parent(1'b1, 1'b0, 2'b01);
    send(2'b11, 4'b0010, 2'd1, 4'b0110, 2'd2);
    checks++;
    if ({sync_o, aggr_o, id_o, src_o} !== {1'b1, 3'b011, 2'd2, 2'b10}) begin
      errors++; $display("FAIL rr_port1_first: got %b expected 10111010", {sync_o, aggr_o, id_o, src_o});
    end
    tick();
    checks++;
    if ({sync_o, aggr_o, id_o, src_o} !== {1'b1, 3'b001, 2'd1, 2'b01}) begin
      errors++; $display("FAIL rr_port0_next: got %b expected 10010101", {sync_o, aggr_o, id_o, src_o});
    end
  endtask

  task automatic test_errors();
    do_reset();
    send(2'b01, 4'b0011, 2'd1, 4'b0000, 2'd0);
    checks++;
    if (error_o !== 2'b00) begin errors++; $display("FAIL err_first_ok: got %b expected 00", error_o); end
    send(2'b01, 4'b0011, 2'd1, 4'b0000, 2'd0);
    checks++;
    if (error_o !== 2'b01) begin errors++; $display("FAIL err_busy: got %b expected 01", error_o); end
    send(2'b10, 4'b0000, 2'd0, 4'b0111, 2'd1);
    checks++;
    if ({error_o, sync_o} !== 3'b100) begin errors++; $display("FAIL err_aggr_mismatch: got %b expected 100", {error_o, sync_o}); end
    send(2'b10, 4'b0000, 2'd0, 4'b0011, 2'd1);
    checks++;
    if ({error_o, sync_o, aggr_o, id_o, src_o} !== {2'b00, 1'b1, 3'b001, 2'd1, 2'b11}) begin
      errors++; $display("FAIL err_table_kept: got %b expected 0010010111", {error_o, sync_o, aggr_o, id_o, src_o});
    end
    parent(1'b0, 1'b1, 2'b10);
    checks++;
    if ({error_o, wake_o} !== 4'b1000) begin errors++; $display("FAIL err_parent: got %b expected 1000", {error_o, wake_o}); end
    send(2'b10, 4'b0000, 2'd0, 4'b0000, 2'd0);
    checks++;
    if (error_o !== 2'b10) begin errors++; $display("FAIL err_aggr_zero: got %b expected 10", error_o); end
    send(2'b10, 4'b0000, 2'd0, 4'b0010, 2'd2);
    checks++;
    if ({error_o, sync_o, aggr_o, id_o, src_o} !== {2'b00, 1'b1, 3'b001, 2'd2, 2'b10}) begin
      errors++; $display("FAIL err_busy_cleared: got %b expected 0010011010", {error_o, sync_o, aggr_o, id_o, src_o});
    end
    parent(1'b1, 1'b0, 2'b11);
    checks++;
    if (wake_o !== 2'b11) begin errors++; $display("FAIL err_wake_both: got %b expected 11", wake_o); end
    parent(1'b1, 1'b1, 2'b11);
    checks++;
    if ({wake_o, error_o} !== 4'b0000) begin errors++; $display("FAIL dst_not_busy: got %b expected 0000", {wake_o, error_o}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(2'b01, 4'b0001, 2'd1, 4'b0000, 2'd0);
    rst_i = 1'b1;
    tick();
    checks++;
    if ({wake_o, error_o, sync_o, aggr_o, id_o, src_o} !== 12'h000) begin
      errors++; $display("FAIL mid_reset_outputs: got %h expected 000", {wake_o, error_o, sync_o, aggr_o, id_o, src_o});
    end
    rst_i = 1'b0;
    send(2'b10, 4'b0000, 2'd0, 4'b0001, 2'd1);
    checks++;
    if ({wake_o, error_o} !== 4'b0000) begin errors++; $display("FAIL mid_no_wake: got %b expected 0000", {wake_o, error_o}); end
    tick();
    checks++;
    if (wake_o !== 2'b00) begin errors++; $display("FAIL mid_still_no_wake: got %b expected 00", wake_o); end
    send(2'b01, 4'b0001, 2'd1, 4'b0000, 2'd0);
    checks++;
    if ({wake_o, error_o} !== 4'b1100) begin errors++; $display("FAIL mid_rerequest: got %b expected 1100", {wake_o, error_o}); end
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    test_reset();
    test_root();
    test_aggregate();
    test_contention();
    test_round_robin();
    test_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fractal_sync_node.md
FRACTAL_SYNC_NODE -- requirements
Module: fractal_sync_node

Interface
REQ-001 SHALL have parameter N_PORTS, default 2: number of child sync ports. Legal range 2..8.
REQ-002 SHALL have parameter AGGR_WIDTH, default 4: width of child aggr. Minimum 2.
REQ-003 SHALL have parameter ID_WIDTH, default 2: barrier id width. The node holds N_BARRIERS = 2**ID_WIDTH table entries.
REQ-004 SHALL have localparam SD_WIDTH = N_PORTS: width of src_o and dst_i, one bit per child.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have ports, in this order:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- sync_i  in  N_PORTS  per-child sync request pulse.
- aggr_i  in  N_PORTS x AGGR_WIDTH  per-child aggr.
- id_i  in  N_PORTS x ID_WIDTH  per-child barrier id.
- wake_o  out  N_PORTS  per-child wake pulse.
- error_o  out  N_PORTS  per-child error pulse.
- sync_o  out  1  parent sync pulse.
- aggr_o  out  AGGR_WIDTH-1  parent aggr (child aggr shifted right by 1).
- id_o  out  ID_WIDTH  parent barrier id.
- src_o  out  SD_WIDTH  children represented by the parent request.
- wake_i  in  1  parent wake pulse.
- dst_i  in  SD_WIDTH  children to wake.
- error_i  in  1  parent error pulse.

Function
REQ-007 SHALL treat a sync_i[p] pulse as one request. The request decodes as follows:
- aggr==0: illegal.
- aggr==1 (leading one at bit 0): root barrier at this node.
- aggr[0]=1 with higher bits set: aggregate here, then forward.
- aggr[0]=0 with aggr!=0: pass-through.
REQ-008 SHALL keep a busy[p] bit per port. Busy is set on an accepted request and cleared in the cycle wake_o[p] or error_o[p] pulses.
REQ-009 SHALL reject the following with error_o[p]=1 in cycle t+1, leaving all state unchanged:
- a request arriving while busy[p]=1;
- a request with aggr==0;
- an aggregating request whose aggr differs from the aggr stored for a non-empty entry with the same id.
REQ-010 SHALL keep, per barrier id, an entry holding: an arrived mask (N_PORTS bits), the stored aggr, and a pending flag.
REQ-011 SHALL set arrived bit p for each accepted aggregating request. The first arrival into an empty entry stores aggr. Multiple ports arriving at the same id in the same cycle SHALL all be recorded.
REQ-012 SHALL declare an entry complete when its arrived mask becomes all ones.
REQ-013 Root completion: wake_o SHALL equal the arrived mask in cycle t+1, where t is the completing arrival cycle. The entry SHALL be cleared at the same edge. No sync_o is issued.
REQ-014 Non-root completion: the entry's pending flag SHALL be set and the entry held until that flag wins arbitration; the entry SHALL be cleared at grant.
REQ-015 Each accepted pass-through request SHALL set a per-port forward-pending bit.
REQ-016 SHALL arbitrate upward requests round-robin, one grant per cycle, over the ordered set:
- barrier-pending flags 0..N_BARRIERS-1, then
- forward-pending bits 0..N_PORTS-1.
After reset the pointer SHALL be at index 0; after each grant it SHALL move to one past the granted index.
REQ-017 A granted item SHALL drive the registered outputs for exactly one cycle: sync_o=1, aggr_o=stored aggr>>1, id_o=id. src_o SHALL be all ones for a barrier grant and one-hot p for a forward grant. The earliest grant is cycle t+1 after the arrival cycle t.
REQ-018 When sync_o=0, SHALL drive aggr_o, id_o and src_o to 0.
REQ-019 On wake_i=1 in cycle t, SHALL drive wake_o |= dst_i in cycle t+1. On error_i=1 in cycle t, SHALL drive error_o |= dst_i in cycle t+1.
REQ-020 Local root wakes, parent wakes and local errors in the same cycle SHALL be ORed per port. A port has at most one outstanding request, so ORing loses no events.
REQ-021 SHALL ignore dst_i bits whose port is not busy.
REQ-022 wake_o and error_o SHALL be registered single-cycle pulses.

Reset
REQ-023 While rst_i=1 at a clock edge, SHALL clear all entries, busy bits and pending bits, and reset the arbiter pointer to 0.
REQ-024 After reset all outputs SHALL be 0.
REQ-025 Reset mid-operation SHALL discard all in-flight barriers without issuing any wake or error.

Verification (N_PORTS=2, AGGR_WIDTH=4, ID_WIDTH=2)
REQ-026 Root barrier: sync_i[0] with aggr=0001 id=1 at t0, then sync_i[1] with aggr=0001 id=1 at t2 -> wake_o=11 at t3; sync_o stays 0.
REQ-027 Aggregate: both ports send aggr=0011 id=2 at t0 -> at t1 sync_o=1, aggr_o=001, id_o=2, src_o=11; then wake_i=1 with dst_i=11 at t5 -> wake_o=11 at t6.
REQ-028 Pass-through plus contention: at t0, port1 sends aggr=0010 id=0 while port0 completes barrier 3 (aggr=0011), with port1 already arrived at 3 earlier -> t1: sync_o with id_o=3, src_o=11; t2: sync_o with id_o=0, aggr_o=001, src_o=10.
REQ-029 Errors:
- busy port0 sends again -> error_o=01 next cycle, table unchanged;
- ports send id=1 with aggr 0011 and 0111 -> error on the second port;
- error_i=1 with dst_i=10 -> error_o=10 next cycle and busy[1] cleared.
REQ-030 Reset mid-operation: port0 arrived at id=1, then rst_i pulses for one cycle, then port1 arrives at id=1 with aggr=0001 -> no wake; port0 is able to re-request without error.
